sigma_sequencer: RTL and testbench
==================================

Name: sigma_sequencer

Overview:
- Upstream control stage for the 4-bit 74181-style ALU (alu_4bit).
- Performs a running summation 1+2+...+n. It drives the ALU operand, function and carry-in ports and consumes the ALU result and carry-out combinationally in the same cycle.
- Replaces free-running testbench feedback with a start/done handshaked sequencer that detects overflow. The ALU itself stays purely combinational.

Parameters:
- WIDTH, 4, datapath width; must match the ALU width.
- ADD_S, 4'h9, ALU function select for A plus B (74181 arithmetic, active-high data).
- ADD_M, 1'b0, ALU mode bit selecting arithmetic.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- n_terms  input  WIDTH  number of terms n; latched on accepted start.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse on completion.
- sum  output  WIDTH  final result; held until the next accepted start.
- ovf  output  1  high if a carry occurred; held with sum.
- alu_a  output  WIDTH  ALU operand A (accumulator).
- alu_b  output  WIDTH  ALU operand B (term counter k).
- alu_s  output  4  ALU function select, constant ADD_S.
- alu_m  output  1  ALU mode, constant ADD_M.
- alu_cin_re  output  1  ALU carry-in, active low; constant 1 (no carry in).
- alu_y  input  WIDTH  ALU result, combinational from alu_a/alu_b.
- alu_cout_re  input  1  ALU carry-out, active low; 0 means carry.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, acc=0, k=0, n=0, sum=0, ovf=0, done=0, busy=0.
  - alu_a=acc=0, alu_b=k=0.
  - alu_s, alu_m and alu_cin_re are constants and are unaffected by reset.
- alu_a and alu_b are driven directly from the registers acc and k, so there is no combinational path from start to the ALU ports.
- States: IDLE, ACC, DONE.
- IDLE:
  - If start=1: latch n<=n_terms, acc<=0, k<=1, sum<=0, ovf<=0.
  - If n_terms==0, go to DONE; otherwise go to ACC.
  - If start=0, hold.
- ACC (busy=1), evaluated each cycle:
  - If alu_cout_re==0: sum<=alu_y, ovf<=1, go to DONE. acc is not updated; the truncated wrap value is what is reported.
  - Else if k==n: acc<=alu_y, sum<=alu_y, go to DONE.
  - Else: acc<=alu_y, k<=k+1 (WIDTH bits; k never wraps because k<=n<=15).
  - Carry takes priority over k==n when both occur in the same cycle.
- DONE:
  - done=1 and busy=1 for exactly this one cycle, then go to IDLE.
  - In IDLE, busy=0 and done=0.
- Latency for n>=1: start sampled at edge T; ACC occupies edges T+1..T+n (fewer on overflow); done is high in the cycle following the final ACC edge.
  - Without overflow: done high n+1 cycles after start is sampled.
  - For n=0: done is high in the cycle after start.
- start while not in IDLE is ignored (no queuing). start in the same cycle that DONE returns to IDLE is also ignored.
- sum and ovf change only on an accepted start (cleared) and at completion.
- Reset asserted mid-operation: on the next edge, return to IDLE with all reset values. No done pulse is produced.
- Arithmetic: all sums are modulo 2^WIDTH. Overflow is signalled solely by alu_cout_re; the block performs no addition of its own.

Test Plan:
- n_terms=5, start pulse -> busy for 6 cycles; alu_b steps 1..5; alu_a steps 0,1,3,6,10; done pulse 6 cycles after start; sum=15 (4'hF), ovf=0.
- n_terms=6 -> overflow on term k=6 (15+6=21): alu_cout_re=0 observed, sum=5, ovf=1, done 7 cycles after start.
- n_terms=15 -> overflow at k=6 as above: sum=5, ovf=1; terms 7..15 never issued; k=6 at done.
- n_terms=0 -> done the cycle after start; sum=0, ovf=0; alu_a and alu_b remain 0.
- n_terms=5 started, then start with n_terms=2 pulsed at ACC cycle 2 -> second start ignored, sum=15. Then assert reset in ACC cycle 3 of a new run -> next cycle busy=0, sum=0, ovf=0, no done pulse.
- Constants: in every state, alu_s=4'h9, alu_m=0, alu_cin_re=1; after reset, sum=0, ovf=0, done=0.

Source files
------------

// File: rtl/sigma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sigma_sequencer
// Brief    : Start/done sequencer computing 1+2+...+n through an external
//            74181-style ALU, with carry-based overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_sequencer #(
  parameter int         WIDTH = 4,
  parameter logic [3:0] ADD_S = 4'h9,
  parameter logic       ADD_M = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_terms,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin_re,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout_re
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q    <= n_terms;
            acc_q  <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            // An empty sum keeps k at 0 so the ALU never sees a term.
            if (n_terms == '0) begin
              k_q     <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              k_q     <= C_ONE;
              state_q <= S_ACC;
            end
          end
        end
        S_ACC: begin
          // Carry wins over k==n; acc keeps its pre-wrap value.
          if (!alu_cout_re) begin
            sum_q   <= alu_y;
            ovf_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (k_q == n_q) begin
            acc_q   <= alu_y;
            sum_q   <= alu_y;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            acc_q <= alu_y;
            k_q   <= k_q + C_ONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign alu_a      = acc_q;
  assign alu_b      = k_q;
  assign alu_s      = ADD_S;
  assign alu_m      = ADD_M;
  assign alu_cin_re = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sigma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_sequencer
// Brief    : Self-checking bench: directed runs against a trace-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_terms = 4'd0;
  logic       busy, done, ovf, alu_m, alu_cin_re, alu_cout_re;
  logic [3:0] sum, alu_a, alu_b, alu_s, alu_y;
  logic [4:0] alu_full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: A plus B, active-low carry out.
  assign alu_full    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_y       = alu_full[3:0];
  assign alu_cout_re = ~alu_full[4];

  sigma_sequencer #(.WIDTH(4), .ADD_S(4'h9), .ADD_M(1'b0)) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .n_terms    (n_terms),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .ovf        (ovf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cin_re (alu_cin_re),
    .alu_y      (alu_y),
    .alu_cout_re(alu_cout_re)
  );

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected per-cycle view of the outputs.
  typedef struct {
    int a, b, busy, done, sum, ovf;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   model_valid = 1'b0;

  // Builds the full output trace of one accepted run from the summation rule.
  function automatic void build(input int n);
    int   acc = 0;
    exp_t e;
    if (n == 0) begin
      e = '{a:0, b:0, busy:1, done:1, sum:0, ovf:0};
    end else begin
      for (int k = 1; k <= n; k++) begin
        q.push_back('{a:acc, b:k, busy:1, done:0, sum:0, ovf:0});
        if (acc + k > 15) begin
          e = '{a:acc, b:k, busy:1, done:1, sum:(acc + k) % 16, ovf:1};
          break;
        end
        acc = acc + k;
        if (k == n) e = '{a:acc, b:k, busy:1, done:1, sum:acc, ovf:0};
      end
    end
    q.push_back(e);
    e.busy = 0;
    e.done = 0;
    q.push_back(e);
  endfunction

  initial begin
    cur = '{a:0, b:0, busy:0, done:0, sum:0, ovf:0};
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        cur = '{a:0, b:0, busy:0, done:0, sum:0, ovf:0};
        model_valid = 1'b1;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (start) begin
        build(int'(n_terms));
        cur = q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("alu_a",      int'(alu_a),      cur.a);
      check("alu_b",      int'(alu_b),      cur.b);
      check("busy",       int'(busy),       cur.busy);
      check("done",       int'(done),       cur.done);
      check("sum",        int'(sum),        cur.sum);
      check("ovf",        int'(ovf),        cur.ovf);
      check("alu_s",      int'(alu_s),      9);
      check("alu_m",      int'(alu_m),      0);
      check("alu_cin_re", int'(alu_cin_re), 1);
    end
  end

  // Issues a start and waits (bounded) for done; returns at the done cycle.
  task automatic run(input logic [3:0] n, input int es, input int eo,
                     input int elat, input string tag);
    int cnt = 0;
    bit seen = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    n_terms = n;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, cnt, elat);
    check({tag, "_sum"}, int'(sum), es);
    check({tag, "_ovf"}, int'(ovf), eo);
  endtask

  initial begin
    int cnt;
    int dones;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", int'(sum), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    run(4'd5, 15, 0, 6, "n5");
    check("n5_alu_b_at_done", int'(alu_b), 5);
    run(4'd6, 5, 1, 7, "n6");
    run(4'd15, 5, 1, 7, "n15");
    check("n15_alu_b_at_done", int'(alu_b), 6);
    run(4'd0, 0, 0, 1, "n0");
    check("n0_alu_a", int'(alu_a), 0);
    check("n0_alu_b", int'(alu_b), 0);
    run(4'd1, 1, 0, 2, "n1");

    // Second start during ACC must be ignored.
    @(negedge clk);
    start = 1'b1; n_terms = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; n_terms = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("midstart_done_seen", int'(done), 1);
    check("midstart_sum", int'(sum), 15);

    // Start presented during the DONE cycle must be ignored.
    start = 1'b1; n_terms = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", int'(busy), 0);
    @(negedge clk);
    check("done_cycle_start_busy2", int'(busy), 0);

    // Reset in ACC cycle 3: back to idle, cleared, no done pulse.
    @(negedge clk);
    start = 1'b1; n_terms = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_sum", int'(sum), 0);
    check("midrst_ovf", int'(ovf), 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run(4'd4, 10, 0, 5, "n4_after_rst");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
